// File: rtl/mem_stage.sv
// MEM stage: ALU results pass straight through; loads/stores run byte-serially
// (little-endian) on a shared 8-bit RAM port while the upstream stages are stalled.
module mem_stage #(
  parameter int RegLen     = 32,
  parameter int RegAddrLen = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [RegLen-1:0]     rd_data_i,
  input  logic [RegAddrLen-1:0] rd_addr_i,
  input  logic                  rd_enable_i,
  input  logic [3:0]            mem_op,
  input  logic [RegLen-1:0]     store_data,
  input  logic                  mem_gnt,
  input  logic [7:0]            mem_rdata,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [RegLen-1:0]     mem_addr,
  output logic [7:0]            mem_wdata,
  output logic [RegLen-1:0]     rd_data_o,
  output logic [RegAddrLen-1:0] rd_addr_o,
  output logic                  rd_enable_o,
  output logic                  stall_req
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  localparam logic [3:0] OP_LB = 4'd1, OP_LH = 4'd2, OP_LW = 4'd3, OP_LBU = 4'd4,
                         OP_LHU = 4'd5, OP_SB = 4'd6, OP_SH = 4'd7, OP_SW = 4'd8;

  state_t                  state_q, state_d;
  logic [1:0]              count_q, count_d;
  logic [3:0]              op_q;
  logic [RegLen-1:0]       base_q;
  logic [RegLen-1:0]       sdata_q;
  logic [RegAddrLen-1:0]   rdaddr_q;
  logic                    rden_q;
  logic [31:0]             buf_word;
  logic [RegLen-1:0]       ld_word;
  logic [1:0]              last_cnt;
  logic                    start;

  function automatic logic is_mem(input logic [3:0] op);
    return (op >= OP_LB) && (op <= OP_SW);
  endfunction

  function automatic logic is_store(input logic [3:0] op);
    return (op >= OP_SB) && (op <= OP_SW);
  endfunction

  assign start = (state_q == IDLE) && is_mem(mem_op);

  always_comb begin
    case (op_q)
      OP_LH, OP_LHU, OP_SH: last_cnt = 2'd1;
      OP_LW, OP_SW:         last_cnt = 2'd3;
      default:              last_cnt = 2'd0;
    endcase
  end

  // One byte lane of the load buffer per genvar; each lane only captures its own index.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic [7:0] lane_q;
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        lane_q <= 8'h00;
      end else if (start) begin
        lane_q <= 8'h00;
      end else if (state_q == ACCESS && mem_gnt && !is_store(op_q) && count_q == 2'(gi)) begin
        lane_q <= mem_rdata;
      end
    end
    assign buf_word[gi*8 +: 8] = lane_q;
  end

  always_comb begin
    ld_word = '0;
    ld_word[31:0] = buf_word;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      count_q  <= 2'd0;
      op_q     <= 4'd0;
      base_q   <= '0;
      sdata_q  <= '0;
      rdaddr_q <= '0;
      rden_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      if (start) begin
        op_q     <= mem_op;
        base_q   <= rd_data_i;
        sdata_q  <= store_data;
        rdaddr_q <= rd_addr_i;
        rden_q   <= rd_enable_i;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = 8'h00;
    rd_data_o   = '0;
    rd_addr_o   = '0;
    rd_enable_o = 1'b0;
    stall_req   = 1'b0;
    case (state_q)
      IDLE: begin
        rd_data_o = rd_data_i;
        rd_addr_o = rd_addr_i;
        if (is_mem(mem_op)) begin
          stall_req = 1'b1;
          count_d   = 2'd0;
          state_d   = ACCESS;
        end else begin
          rd_enable_o = rd_enable_i;
        end
      end
      ACCESS: begin
        mem_req   = 1'b1;
        mem_we    = is_store(op_q);
        mem_addr  = base_q + RegLen'(count_q);
        mem_wdata = sdata_q[8*count_q +: 8];
        stall_req = 1'b1;
        rd_addr_o = rdaddr_q;
        if (mem_gnt) begin
          if (count_q == last_cnt) state_d = DONE;
          else count_d = count_q + 2'd1;
        end
      end
      DONE: begin
        rd_addr_o = rdaddr_q;
        state_d   = IDLE;
        if (!is_store(op_q)) begin
          rd_enable_o = rden_q;
          case (op_q)
            OP_LB:   rd_data_o = {{(RegLen-8){buf_word[7]}}, buf_word[7:0]};
            OP_LH:   rd_data_o = {{(RegLen-16){buf_word[15]}}, buf_word[15:0]};
            OP_LBU:  rd_data_o = {{(RegLen-8){1'b0}}, buf_word[7:0]};
            OP_LHU:  rd_data_o = {{(RegLen-16){1'b0}}, buf_word[15:0]};
            default: rd_data_o = ld_word;
          endcase
        end
      end
      default: state_d = IDLE;
    endcase
    // Reset forces every output low, including the IDLE pass-through path.
    if (!rst) begin
      mem_req     = 1'b0;
      mem_we      = 1'b0;
      mem_addr    = '0;
      mem_wdata   = 8'h00;
      rd_data_o   = '0;
      rd_addr_o   = '0;
      rd_enable_o = 1'b0;
      stall_req   = 1'b0;
    end
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- MEM stage of the five-stage integer pipeline. Sits between the EX/MEM pipeline register, which carries the EX results, and the MEM/WB register.
- Non-memory instructions pass straight through with zero latency.
- Loads and stores run as a byte-serial sequence on the shared 8-bit RAM port, little-endian. While the sequence runs, the block holds stall_req high to freeze the upstream stages.

Parameters:
- RegLen, 32, data/address width in bits.
- RegAddrLen, 5, register index width.

Ports:
- clk  in  1  pipeline clock.
- rst  in  1  asynchronous, active-low reset.
- rd_data_i  in  RegLen  ALU result from EX/MEM; this is the effective address for memory ops.
- rd_addr_i  in  RegAddrLen  destination register.
- rd_enable_i  in  1  destination write enable.
- mem_op  in  4  memory op code: 0 NONE, 1 LB, 2 LH, 3 LW, 4 LBU, 5 LHU, 6 SB, 7 SH, 8 SW. Codes 9-15 are treated as NONE.
- store_data  in  RegLen  rs2 value for stores.
- mem_gnt  in  1  RAM controller accepts the current byte this cycle.
- mem_rdata  in  8  read byte; valid in any cycle where mem_gnt=1 and mem_we=0.
- mem_req  out  1  byte access request.
- mem_we  out  1  1 = write, 0 = read.
- mem_addr  out  RegLen  byte address.
- mem_wdata  out  8  write byte.
- rd_data_o  out  RegLen  writeback data to MEM/WB.
- rd_addr_o  out  RegAddrLen  writeback register.
- rd_enable_o  out  1  writeback enable.
- stall_req  out  1  freeze request to the pipeline controller.

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE; byte counter and byte buffer clear to 0.
  - All outputs are 0.
  - An access in progress is abandoned: no further mem_req, and no partial writeback.
- FSM states are IDLE, ACCESS and DONE. N = 1 for B ops, 2 for H ops, 4 for W ops.
- IDLE, mem_op = NONE:
  - Combinational pass-through: rd_data_o=rd_data_i, rd_addr_o=rd_addr_i, rd_enable_o=rd_enable_i.
  - stall_req=0, mem_req=0.
- IDLE, memory op present:
  - stall_req=1 combinationally in the same cycle; rd_enable_o=0.
  - On the next edge, latch op, base address, store_data, rd_addr_i and rd_enable_i; set count=0; go to ACCESS.
- ACCESS outputs:
  - mem_req=1; mem_addr=base+count, modulo 2^RegLen (wraps past all-ones).
  - mem_we=1 for stores; mem_wdata=store_data byte[count], with byte 0 = bits 7:0.
  - stall_req=1; rd_enable_o=0.
- ACCESS stepping:
  - mem_gnt=0: hold every output stable; the wait is unbounded.
  - mem_gnt=1 on a load: capture mem_rdata into buffer byte[count].
  - mem_gnt=1: count increments. If count was N-1, go to DONE instead.
  - No alignment restriction: misaligned H/W accesses are simply more bytes at consecutive addresses.
- DONE (exactly one cycle):
  - stall_req=0, mem_req=0; rd_addr_o = latched value.
  - Loads: rd_enable_o = latched rd_enable. rd_data_o:
    - LB/LH: sign-extended from bit 7/15.
    - LBU/LHU: zero-extended.
    - LW: the full buffer.
  - Stores: rd_enable_o=0, rd_data_o=0.
  - Pipeline advances on this edge. Next state is IDLE unconditionally, so the still-present mem_op is never re-issued.
- Latency:
  - Memory op occupies (cycles in IDLE = 1) + (N + total gnt wait cycles) + 1 DONE cycle.
  - With mem_gnt tied high: LW = 6 cycles, LB = 3 cycles.
- Inputs are ignored outside IDLE; the latched copies are used.
- mem_gnt arriving while mem_req=0 is ignored.

Test Plan:
- ALU pass-through: mem_op=0, rd_data_i=0xDEADBEEF, rd_addr_i=5, rd_enable_i=1 -> same values on outputs in the same cycle; stall_req=0; mem_req never asserted.
- LW, gnt tied high: addr 0x100; RAM[0x100..0x103] = 78,56,34,12 -> mem_addr steps 0x100..0x103 in consecutive cycles; DONE gives rd_data_o=0x12345678, rd_enable_o=1; stall_req high for exactly 5 cycles.
- Sign/zero extension, RAM[0x40]=0x80:
  - LB -> 0xFFFFFF80.
  - LBU -> 0x00000080.
  - LH with RAM[0x41]=0x00 -> 0x00000080.
  - LH with RAM[0x41]=0xFF -> 0xFFFFFF80.
- Misaligned SH with gnt stalls: store_data=0x0000ABCD, addr 0x3; mem_gnt withheld 3 cycles before each byte -> writes 0xCD@0x3 then 0xAB@0x4; outputs stable during waits; rd_enable_o=0 at DONE.
- Address wrap: LW at 0xFFFFFFFE -> accesses 0xFFFFFFFE, 0xFFFFFFFF, 0x0, 0x1.
- Reset mid-LW: rst=0 after the 2nd byte grant -> all outputs 0 immediately; after release, mem_op=NONE gives pass-through; a new LB runs cleanly from count 0.
